sseg_display_arbiter: RTL

//   Owns the 6-digit seven-segment display of the pulse generator.

---
 rtl/sseg_pkg.sv | 20 ++
 rtl/sseg_tick_gen.sv | 24 ++
 rtl/sseg_display_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared owner encodings, display constants and leading-zero blanking helper
package sseg_pkg;
    typedef enum logic [1:0] {
        OWN_MON  = 2'd0,
        OWN_EDIT = 2'd1,
        OWN_MSG  = 2'd2
    } owner_t;
    localparam int NUM_DIGITS = 6;
    localparam logic [2:0] CURSOR_NONE = 3'd7;
    // Blank zero nibbles from the top down until the first non-zero one; digit 0 always shows.
    function automatic logic [5:0] lzb_mask(input logic [23:0] d);
        logic lead;
        lead = 1'b1;
        lzb_mask = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead = lead && (d[4*i +: 4] == 4'd0);
            lzb_mask[i] = lead;
        end
    endfunction
endpackage

// File: rtl/sseg_tick_gen.sv
// sseg_tick_gen: sweep prescaler and digit index; flags the frame boundary on the last digit's tick
module sseg_tick_gen #(
    parameter int DIV = 6
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tick,
    output logic [2:0] digit_idx,
    output logic       fb
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt;
    assign tick = cnt == CW'(DIV - 1);
    assign fb = tick && digit_idx == 3'd5;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            digit_idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) digit_idx <= digit_idx == 3'd5 ? 3'd0 : digit_idx + 3'd1;
        end
    end
endmodule

// File: rtl/sseg_display_arbiter.sv
// sseg_display_arbiter: shares the 6-digit display between message, editor and monitor,
// latching content only on frame boundaries so the display never tears
module sseg_display_arbiter
    import sseg_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SWEEP_HZ     = 6_000,
    parameter int HOLD_FRAMES  = 1_500,
    parameter int BLINK_FRAMES = 250,
    parameter int LZB          = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] mon_data,
    input  logic        edit_req,
    input  logic [23:0] edit_data,
    input  logic [2:0]  edit_cursor,
    input  logic        msg_valid,
    input  logic [23:0] msg_data,
    output logic        msg_ready,
    output logic        sweep_tick,
    output logic [2:0]  digit_idx,
    output logic [23:0] disp_data,
    output logic [5:0]  disp_blank,
    output logic [1:0]  owner
);
    localparam int DIV = CLK_HZ / SWEEP_HZ;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    owner_t state, next_state;
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] blink_cnt;
    logic blink_phase, fb, hold_done, blink_wrap;
    logic [23:0] msg_buf, sel_data;
    logic [5:0] sel_blank;
    sseg_tick_gen #(.DIV(DIV)) u_tick (
        .clk(clock),
        .rst(reset),
        .tick(sweep_tick),
        .digit_idx(digit_idx),
        .fb(fb)
    );
    assign owner = state;
    assign msg_ready = !reset && state != OWN_MSG;
    assign hold_done = fb && hold_cnt == HW'(HOLD_FRAMES - 1);
    assign blink_wrap = blink_cnt == BW'(BLINK_FRAMES - 1);
    // Handshake outranks the editor level; during a message only hold expiry moves the owner.
    always_comb begin
        next_state = state;
        if (state == OWN_MSG) begin
            if (hold_done) next_state = edit_req ? OWN_EDIT : OWN_MON;
        end else begin
            next_state = msg_valid ? OWN_MSG : edit_req ? OWN_EDIT : OWN_MON;
        end
    end
    always_comb begin
        sel_data = state == OWN_MSG ? msg_buf : state == OWN_EDIT ? edit_data : mon_data;
        sel_blank = state == OWN_MSG ? 6'd0
                  : state == OWN_EDIT ? ((blink_phase && edit_cursor < 3'(NUM_DIGITS)) ? 6'd1 << edit_cursor : 6'd0)
                  : (LZB != 0 ? lzb_mask(mon_data) : 6'd0);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= OWN_MON;
            hold_cnt <= '0;
            blink_cnt <= '0;
            blink_phase <= 1'b0;
            msg_buf <= '0;
            disp_data <= '0;
            disp_blank <= 6'b111111;
        end else begin
            state <= next_state;
            if (state != OWN_MSG) hold_cnt <= '0;
            else if (fb) hold_cnt <= hold_cnt + 1'b1;
            if (msg_valid && msg_ready) msg_buf <= msg_data;
            if (fb) begin
                blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
                if (blink_wrap) blink_phase <= ~blink_phase;
                disp_data <= sel_data;
                disp_blank <= sel_blank;
            end
        end
    end
endmodule
